muldiv_scheduler: RTL

Two-port arbiter and sequencer in front of the MULDIV2 execution unit, which implements instruction set M.
- It accepts M-extension requests from two requesters: port 0 is the core execute stage, port 1 is the auxiliary/coprocessor port.
- It grants them round-robin and drives the unit's operand, funct3 and start inputs.
- It waits the fixed multiply latency or polls the divider busy flag, captures the result, and returns it on a valid/ready response channel to the owning port.
- Only one operation is in flight at a time.

---
 rtl/muldiv_scheduler.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/muldiv_scheduler.sv
// muldiv_scheduler
// Two-port round-robin arbiter and sequencer in front of the MULDIV2 unit.
// Accepts one M-extension request at a time, issues it to the unit, waits
// the fixed multiply latency or the divider busy flag, then returns the
// captured result on the owning port's valid/ready response channel.
//
// Ports
//   clk, rstLow                      clock, async active-low reset
//   reqN_valid_i / reqN_ready_o      request handshake, N = 0 (execute), 1 (aux)
//   reqN_rs1_i, reqN_rs2_i           operands
//   reqN_funct3_i                    M-extension funct3
//   respN_valid_o / respN_ready_i    response handshake
//   respN_result_o                   captured result
//   md_rs1_o, md_rs2_o, md_funct3_o  operands/funct3 to MULDIV2 (registered)
//   md_start_o                       one-cycle start pulse to MULDIV2
//   md_busy_i, md_c_i                MULDIV2 busy flag and result
module muldiv_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rstLow,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [DATA_WIDTH-1:0] req0_rs1_i,
  input  logic [DATA_WIDTH-1:0] req0_rs2_i,
  input  logic [2:0]            req0_funct3_i,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [DATA_WIDTH-1:0] req1_rs1_i,
  input  logic [DATA_WIDTH-1:0] req1_rs2_i,
  input  logic [2:0]            req1_funct3_i,
  output logic                  resp0_valid_o,
  input  logic                  resp0_ready_i,
  output logic [DATA_WIDTH-1:0] resp0_result_o,
  output logic                  resp1_valid_o,
  input  logic                  resp1_ready_i,
  output logic [DATA_WIDTH-1:0] resp1_result_o,
  output logic [DATA_WIDTH-1:0] md_rs1_o,
  output logic [DATA_WIDTH-1:0] md_rs2_o,
  output logic [2:0]            md_funct3_o,
  output logic                  md_start_o,
  input  logic                  md_busy_i,
  input  logic [DATA_WIDTH-1:0] md_c_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] LAT_INIT = (MUL_LAT == 0) ? 3'd0 : 3'(MUL_LAT - 1);

  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_rs1, r_rs2, r_result;
  logic [2:0]            r_funct3, r_lat_cnt;
  logic                  r_owner, r_last;
  logic                  w_grant0, w_grant1;
  logic                  w_accept, w_capture, w_load_lat, w_dec_lat;

  // r_last = 1 means port 1 was granted last, so port 0 wins a tie.
  // Ready is masked by rstLow so it drops in the same cycle reset asserts.
  assign w_grant0 = rstLow & req0_valid_i & (~req1_valid_i | r_last);
  assign w_grant1 = rstLow & req1_valid_i & ~w_grant0;

  always_ff @(posedge clk or negedge rstLow) begin
    if (!rstLow) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_capture     = 1'b0;
    w_load_lat    = 1'b0;
    w_dec_lat     = 1'b0;
    req0_ready_o  = 1'b0;
    req1_ready_o  = 1'b0;
    md_start_o    = 1'b0;
    resp0_valid_o = 1'b0;
    resp1_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready_o = w_grant0;
        req1_ready_o = w_grant1;
        if (w_grant0 | w_grant1) begin
          w_accept = 1'b1;
          w_next   = ISSUE;
        end
      end
      ISSUE: begin
        md_start_o = 1'b1;
        if (!r_funct3[2]) begin
          if (MUL_LAT == 0) begin
            w_capture = 1'b1;
            w_next    = RESP;
          end else begin
            w_load_lat = 1'b1;
            w_next     = WAIT;
          end
        end else if (!md_busy_i) begin
          // divide resolved in the start cycle (special case or remainder shortcut)
          w_capture = 1'b1;
          w_next    = RESP;
        end else begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        if (!r_funct3[2]) begin
          if (r_lat_cnt == 3'd0) begin
            w_capture = 1'b1;
            w_next    = RESP;
          end else begin
            w_dec_lat = 1'b1;
          end
        end else if (!md_busy_i) begin
          w_capture = 1'b1;
          w_next    = RESP;
        end
      end
      RESP: begin
        resp0_valid_o = ~r_owner;
        resp1_valid_o = r_owner;
        if (r_owner ? resp1_ready_i : resp0_ready_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand registers only move on acceptance so the unit's
  // quotient-then-remainder shortcut survives idle periods.
  always_ff @(posedge clk or negedge rstLow) begin
    if (!rstLow) begin
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_funct3  <= '0;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_lat_cnt <= '0;
      r_result  <= '0;
    end else begin
      if (w_accept) begin
        r_rs1    <= w_grant0 ? req0_rs1_i    : req1_rs1_i;
        r_rs2    <= w_grant0 ? req0_rs2_i    : req1_rs2_i;
        r_funct3 <= w_grant0 ? req0_funct3_i : req1_funct3_i;
        r_owner  <= w_grant1;
        r_last   <= w_grant1;
      end
      if (w_load_lat)     r_lat_cnt <= LAT_INIT;
      else if (w_dec_lat) r_lat_cnt <= r_lat_cnt - 3'd1;
      if (w_capture)      r_result  <= md_c_i;
    end
  end

  assign md_rs1_o       = r_rs1;
  assign md_rs2_o       = r_rs2;
  assign md_funct3_o    = r_funct3;
  assign resp0_result_o = r_result;
  assign resp1_result_o = r_result;

endmodule
